regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised MIPS register file with two combinational read ports, one write port, write-to-read bypass, hardwired zero register and a per-register busy scoreboard. Decode uses it to read operands and detect RAW/WAW hazards against in-flight producers (loads, multi-cycle ops); writeback clears the busy state. It replaces the single-width negedge register file in the core datapath and moves all state to the rising edge.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, ≥2)
- AW, $clog2(DEPTH), register index width (derived, not overridden)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes, is never busy

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- raA  in  AW  read address A
- raB  in  AW  read address B
- useA  in  1  operand A is needed by the instruction in decode
- useB  in  1  operand B is needed
- rdA  out  WIDTH  read data A (bypassed)
- rdB  out  WIDTH  read data B (bypassed)
- wen  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  WIDTH  writeback data
- iss_en  in  1  decode requests issue of an instruction with a destination
- iss_wa  in  AW  destination register of issuing instruction
- iss_ack  out  1  issue accepted this cycle (iss_en & ~stall)
- stall  out  1  hazard; decode must hold
- busy_vec  out  DEPTH  current busy bits (debug/verification)

## Operation
- Storage: DEPTH × WIDTH registers, busy[DEPTH] bits.
- Reset (reset=1 at rising edge): every register, including the highest index, ← 0; busy ← 0. Reset has priority over writes and issues in the same cycle. During reset cycle outputs: iss_ack=0, stall=0.
- Write: on rising edge with wen=1 and reset=0, reg[wa] ← wd; busy[wa] ← 0. If ZERO_REG and wa=0: no effect.
- Read: rdX = 0 if ZERO_REG and raX=0; else wd if wen and wa=raX; else reg[raX]. Bypass is write-first.
- Effective busy: bX = busy[raX] & ~(wen & wa=raX); 0 for r0 when ZERO_REG.
- stall = (useA & bA) | (useB & bB) | (iss_en & bW), bW = effective busy of iss_wa (WAW).
- iss_ack = iss_en & ~stall. On ack: busy[iss_wa] ← 1 (skipped for r0 when ZERO_REG).
- Simultaneous writeback and accepted issue to same register: data written, busy ends 1 (new producer wins).
- Writeback to a non-busy register is legal: data written, busy stays 0.
- Out-of-range addresses impossible (DEPTH power of two).

## Timing
- Reads, bypass, stall, iss_ack: combinational, zero latency.
- Writes and busy updates: visible at register outputs one edge after the cycle presented; visible same cycle via bypass.
- Issue → dependant stalls starting next cycle until the cycle writeback is presented (that cycle, bypass delivers data, no stall).
- Minimum producer-to-consumer: writeback cycle = consumer read cycle.

## Structure
- Shared package mips_pkg: WIDTH default, reg-index typedef for default DEPTH, REG_ZERO constant.
- Optional sub-module regfile_busy_tracker: busy bits, effective-busy, stall/iss_ack logic; data array and bypass stay in top.

## Test plan
- Reset with all regs pre-written 0xFFFF_FFFF → all 32 read 0 (incl. r31), busy_vec=0.
- Write r5=0xDEAD_BEEF, same cycle raA=5 → rdA=0xDEAD_BEEF; next cycle still 0xDEAD_BEEF; write r0=0x1234 → r0 reads 0.
- Issue iss_wa=7 (ack=1), next cycle raA=7,useA=1 → stall=1 for 3 cycles; writeback r7=0x55 → stall=0, rdA=0x55 that cycle; busy_vec[7]=0 after.
- busy r9, iss_en with iss_wa=9 → stall=1, iss_ack=0; writeback r9 same cycle → iss_ack=1, busy_vec[9]=1 next cycle.
- Writeback r3 and accepted issue r3 same edge → reg[3] updated, busy_vec[3]=1.
- reset asserted with wen=1, iss_en=1 → all regs 0, busy 0 next cycle, iss_ack=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// Provides the default datapath width and register count, the register-index
// type for the default register count, and the index of the hardwired zero
// register. No ports; imported by the register file and its busy tracker.
package mips_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;

  typedef logic [$clog2(DEPTH_DEF)-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard for the register file.
// Holds one busy bit per register, computes effective busy (a writeback
// presented this cycle already satisfies a waiting reader), raises stall on
// RAW hazards for used operands and on WAW hazards for an issuing destination,
// and marks the destination busy when an issue is accepted.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   raA, raB           operand read addresses
//   useA, useB         operand actually needed by the instruction in decode
//   wen, wa            writeback enable / address (clears busy)
//   iss_en, iss_wa     issue request / destination register
//   stall, iss_ack     hazard indication / issue accepted this cycle
//   busy_vec           current busy bits
module regfile_busy_tracker
  import mips_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    raA,
  input  logic [AW-1:0]    raB,
  input  logic             useA,
  input  logic             useB,
  input  logic             wen,
  input  logic [AW-1:0]    wa,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_wa,
  output logic             stall,
  output logic             iss_ack,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             bA;
  logic             bB;
  logic             bW;
  logic             hazard;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == AW'(REG_ZERO));
  endfunction

  // A register being written back this cycle is no longer a hazard: the
  // reader picks the value up through the bypass.
  function automatic logic eff_busy(input logic [AW-1:0] a);
    return busy_q[a] && !(wen && (wa == a)) && !is_zero(a);
  endfunction

  always_comb begin
    bA      = eff_busy(raA);
    bB      = eff_busy(raB);
    bW      = eff_busy(iss_wa);
    hazard  = (useA && bA) || (useB && bB) || (iss_en && bW);
    stall   = !reset && hazard;
    iss_ack = !reset && iss_en && !hazard;

    busy_d = busy_q;
    if (wen) begin
      busy_d[wa] = 1'b0;
    end
    // Set after the clear so a new producer wins over a same-cycle writeback.
    if (iss_ack) begin
      busy_d[iss_wa] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// MIPS register file with scoreboard.
// Two combinational read ports with write-first bypass, one write port, an
// optional hardwired zero register and a per-register busy scoreboard used by
// decode for RAW/WAW hazard detection. All state updates on the rising edge.
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   raA/raB, useA/useB read addresses and operand-needed flags
//   rdA/rdB            read data (bypassed from the write port)
//   wen, wa, wd        writeback enable / address / data
//   iss_en, iss_wa     issue request and its destination register
//   iss_ack, stall     issue accepted / hazard, decode must hold
//   busy_vec           busy bits, for debug and verification
module regfile_sb
  import mips_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    raA,
  input  logic [AW-1:0]    raB,
  input  logic             useA,
  input  logic             useB,
  output logic [WIDTH-1:0] rdA,
  output logic [WIDTH-1:0] rdB,
  input  logic             wen,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_wa,
  output logic             iss_ack,
  output logic             stall,
  output logic [DEPTH-1:0] busy_vec
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == AW'(REG_ZERO));
  endfunction

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
    if (is_zero(a)) begin
      return '0;
    end else if (wen && (wa == a)) begin
      return wd;
    end else begin
      return regs_q[a];
    end
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wen && !is_zero(wa)) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdA = read_port(raA);
    rdB = read_port(raB);
  end

  regfile_busy_tracker #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clock    (clock),
    .reset    (reset),
    .raA      (raA),
    .raB      (raB),
    .useA     (useA),
    .useB     (useB),
    .wen      (wen),
    .wa       (wa),
    .iss_en   (iss_en),
    .iss_wa   (iss_wa),
    .stall    (stall),
    .iss_ack  (iss_ack),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// register/busy array model.
module tb_regfile_sb;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clock;
  logic             reset;
  logic [AW-1:0]    raA, raB;
  logic             useA, useB;
  logic [WIDTH-1:0] rdA, rdB;
  logic             wen;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             iss_en;
  logic [AW-1:0]    iss_wa;
  logic             iss_ack;
  logic             stall;
  logic [DEPTH-1:0] busy_vec;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [WIDTH-1:0] m_regs [DEPTH];
  bit               m_busy [DEPTH];

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
    .clock(clock), .reset(reset), .raA(raA), .raB(raB), .useA(useA), .useB(useB),
    .rdA(rdA), .rdB(rdB), .wen(wen), .wa(wa), .wd(wd), .iss_en(iss_en),
    .iss_wa(iss_wa), .iss_ack(iss_ack), .stall(stall), .busy_vec(busy_vec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [WIDTH-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (wen && int'(wa) == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_waiting(input int a);
    return (a != 0) && m_busy[a] && !(wen && int'(wa) == a);
  endfunction

  function automatic bit m_stall();
    if (reset) return 1'b0;
    return (useA && m_waiting(int'(raA))) || (useB && m_waiting(int'(raB))) ||
           (iss_en && m_waiting(int'(iss_wa)));
  endfunction

  function automatic bit m_ack();
    if (reset) return 1'b0;
    return iss_en && !((useA && m_waiting(int'(raA))) || (useB && m_waiting(int'(raB))) ||
                       m_waiting(int'(iss_wa)));
  endfunction

  always @(posedge clock) begin
    bit ack;
    ack = m_ack();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (wen && wa != 0) begin
        m_regs[wa] <= wd;
        m_busy[wa] <= 1'b0;
      end
      if (ack && iss_wa != 0) m_busy[iss_wa] <= 1'b1;
    end
  end

  always @(negedge clock) begin
    logic [DEPTH-1:0] bv;
    if (chk_en) begin
      for (int i = 0; i < DEPTH; i++) bv[i] = m_busy[i];
      chk("model_rdA", rdA, m_read(int'(raA)));
      chk("model_rdB", rdB, m_read(int'(raB)));
      chk("model_stall", {31'b0, stall}, {31'b0, m_stall()});
      chk("model_iss_ack", {31'b0, iss_ack}, {31'b0, m_ack()});
      chk("model_busy_vec", busy_vec, bv);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; raA = '0; raB = '0; useA = 0; useB = 0;
    wen = 0; wa = '0; wd = '0; iss_en = 0; iss_wa = '0;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    chk_en = 1;
    tick();
    reset = 0;

    // Fill every register with ones and leave r4 busy before resetting.
    for (int i = 0; i < DEPTH; i++) begin
      wen = 1; wa = AW'(i); wd = 32'hFFFF_FFFF;
      tick();
    end
    idle();
    iss_en = 1; iss_wa = 5'd4;
    #2 chk("issue_r4_ack", {31'b0, iss_ack}, 32'd1);
    tick();
    idle();

    // Reset wins over simultaneous writeback and issue.
    reset = 1; wen = 1; wa = 5'd31; wd = 32'hFFFF_FFFF; iss_en = 1; iss_wa = 5'd12;
    #2;
    chk("reset_iss_ack", {31'b0, iss_ack}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    tick();
    idle();
    #2 chk("post_reset_busy", busy_vec, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      raA = AW'(i);
      #2 chk($sformatf("post_reset_r%0d", i), rdA, 32'd0);
      tick();
    end
    idle();

    // Write with same-cycle bypass, then r0 ignores writes.
    wen = 1; wa = 5'd5; wd = 32'hDEAD_BEEF; raA = 5'd5;
    #2 chk("bypass_r5", rdA, 32'hDEAD_BEEF);
    tick();
    wen = 0;
    #2 chk("stored_r5", rdA, 32'hDEAD_BEEF);
    tick();
    wen = 1; wa = 5'd0; wd = 32'h0000_1234; raA = 5'd0;
    #2 chk("r0_bypass_zero", rdA, 32'd0);
    tick();
    wen = 0;
    #2 chk("r0_stored_zero", rdA, 32'd0);
    tick();
    idle();

    // RAW: producer of r7 stalls its consumer until writeback is presented.
    iss_en = 1; iss_wa = 5'd7;
    #2 chk("issue_r7_ack", {31'b0, iss_ack}, 32'd1);
    tick();
    idle();
    raA = 5'd7; useA = 1;
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("raw_stall_%0d", i), {31'b0, stall}, 32'd1);
      tick();
    end
    wen = 1; wa = 5'd7; wd = 32'h0000_0055;
    #2;
    chk("raw_release_stall", {31'b0, stall}, 32'd0);
    chk("raw_release_rdA", rdA, 32'h0000_0055);
    tick();
    idle();
    #2 chk("r7_not_busy", {31'b0, busy_vec[7]}, 32'd0);
    tick();

    // WAW: second producer of r9 held until the first writes back.
    iss_en = 1; iss_wa = 5'd9;
    tick();
    #2;
    chk("waw_stall", {31'b0, stall}, 32'd1);
    chk("waw_no_ack", {31'b0, iss_ack}, 32'd0);
    tick();
    wen = 1; wa = 5'd9; wd = 32'h0000_0099;
    #2 chk("waw_ack_on_wb", {31'b0, iss_ack}, 32'd1);
    tick();
    idle();
    #2 chk("r9_busy_again", {31'b0, busy_vec[9]}, 32'd1);
    wen = 1; wa = 5'd9; wd = 32'h0000_0999;
    tick();
    idle();

    // Writeback and accepted issue to the same register: new producer wins.
    wen = 1; wa = 5'd3; wd = 32'h0000_ABCD; iss_en = 1; iss_wa = 5'd3;
    #2 chk("same_edge_ack", {31'b0, iss_ack}, 32'd1);
    tick();
    idle();
    raA = 5'd3;
    #2;
    chk("same_edge_busy", {31'b0, busy_vec[3]}, 32'd1);
    chk("same_edge_data", rdA, 32'h0000_ABCD);
    tick();

    // Randomized traffic; narrow address range in bursts to force collisions.
    for (int n = 0; n < 4000; n++) begin
      int span;
      span = (n % 1000 < 500) ? 7 : 31;
      reset  = ($urandom_range(0, 299) == 0);
      raA    = AW'($urandom_range(0, span));
      raB    = AW'($urandom_range(0, span));
      useA   = $urandom_range(0, 1);
      useB   = $urandom_range(0, 1);
      wen    = ($urandom_range(0, 9) < 4);
      wa     = AW'($urandom_range(0, span));
      wd     = $urandom;
      iss_en = ($urandom_range(0, 9) < 4);
      iss_wa = AW'($urandom_range(0, span));
      tick();
    end
    idle();
    tick();
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
